// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder: FSM state encoding and
// helpers that derive the chunk count and the chunk-index width.
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a one-bit index register
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit pair CHUNK bits per cycle,
// LSB first, with a registered carry and valid/ready handshakes on both sides.
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cy_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cy_out,
    output logic             ovf
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t state, next_state;

    logic [WIDTH-1:0]       a_r, b_r, sum_r;
    logic [IW-1:0]          idx;
    logic                   carry, a_msb, b_msb, cy_r, ovf_r;
    logic [CHUNK-1:0]       s_chunk;
    logic                   c_next;
    logic                   last;
    logic [WIDTH+CHUNK-1:0] sum_cat;

    assign last = (idx == LAST_IDX);

    // Operand registers shift right each RUN cycle so the adder always sees the low chunk
    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (a_r[CHUNK-1:0]),
        .b    (b_r[CHUNK-1:0]),
        .cin  (carry),
        .s    (s_chunk),
        .cout (c_next)
    );

    assign sum_cat = {s_chunk, sum_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last)      next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result chunks enter at the top of sum_r and reach their final place after NCHUNK shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            idx   <= '0;
            carry <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            cy_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cy_in;
                        a_msb <= a[WIDTH-1];
                        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        idx   <= '0;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    sum_r <= sum_cat[WIDTH+CHUNK-1:CHUNK];
                    carry <= c_next;
                    if (last) begin
                        cy_r  <= c_next;
                        ovf_r <= (a_msb == b_msb) && (s_chunk[CHUNK-1] != a_msb);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cy_out    = cy_r;
    assign ovf       = ovf_r;

endmodule
